// File: rtl/approx_adder_pipe.sv
// -----------------------------------------------------------------------------
// approx_adder_pipe
//
// Pipelined approximate ripple adder with an on-line error monitor.
//
// The WIDTH-bit carry chain is split into STAGES slices of SW = WIDTH/STAGES
// bits. Slice j is computed in stage j from the carry registered by stage j-1
// and the operands carried alongside the beat. The last stage register is the
// output register, so a beat accepted at edge n is visible after edge
// n+STAGES-1.
//
// The low k cells (k = appr_k clamped to APPR_MAX) are approximate cells:
//   cout_i = a_i,  s_i = (~a_i & (b_i | c_i)) | (a_i & b_i & c_i)
// All other cells are exact full adders. An exact sum rides in the same
// pipeline so the output stage can flag beats whose result differs.
//
// Handshake: a beat moves on an edge where valid & ready are both high.
// The whole pipe advances when en = ~out_valid | out_ready and freezes
// otherwise; in_ready = en, so nothing is dropped or duplicated.
//
// Parameters:
//   WIDTH    operand/sum width, must be a multiple of STAGES
//   STAGES   number of pipeline register stages (last one drives outputs)
//   APPR_MAX maximum number of approximate LSB cells, APPR_MAX <= WIDTH
//   KW       width of appr_k
//   CNTW     error counter width
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid, in_ready    input handshake
//   a, b, cin, appr_k     operands, carry in, approximate cell count
//   out_valid, out_ready  output handshake
//   s, cout               approximate sum and carry out
//   err                   current output beat differs from exact a+b+cin
//   err_cnt               saturating count of delivered erroneous beats
//   cnt_clr               synchronous clear of err_cnt (wins over increment)
// -----------------------------------------------------------------------------
module approx_adder_pipe #(
    parameter int WIDTH    = 24,
    parameter int STAGES   = 3,
    parameter int APPR_MAX = 8,
    parameter int KW       = $clog2(APPR_MAX + 1),
    parameter int CNTW     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [KW-1:0]    appr_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             err,
    output logic [CNTW-1:0]  err_cnt,
    input  logic             cnt_clr
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: valid, clamped k, operands (skew), approximate and
    // exact partial sums and carries.
    logic             v_q   [STAGES];
    logic [KW-1:0]    k_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sap_q [STAGES];
    logic [WIDTH-1:0] sex_q [STAGES];
    logic             cap_q [STAGES];
    logic             cex_q [STAGES];

    logic             v_d   [STAGES];
    logic [KW-1:0]    k_d   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sap_d [STAGES];
    logic [WIDTH-1:0] sex_d [STAGES];
    logic             cap_d [STAGES];
    logic             cex_d [STAGES];

    logic [CNTW-1:0]  err_cnt_q;
    logic [CNTW-1:0]  err_cnt_d;
    logic [KW-1:0]    k_in;
    logic             en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Out-of-range requests saturate to the largest supported approximation.
    assign k_in = (appr_k > KW'(APPR_MAX)) ? KW'(APPR_MAX) : appr_k;

    always_comb begin : stage_logic
        logic             src_v;
        logic [KW-1:0]    src_k;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] sum_ap;
        logic [WIDTH-1:0] sum_ex;
        logic             c_ap;
        logic             c_ex;
        logic             ai;
        logic             bi;
        int               idx;
        int               jp;
        src_v  = 1'b0;
        src_k  = '0;
        src_a  = '0;
        src_b  = '0;
        sum_ap = '0;
        sum_ex = '0;
        c_ap   = 1'b0;
        c_ex   = 1'b0;
        ai     = 1'b0;
        bi     = 1'b0;
        idx    = 0;
        jp     = 0;
        for (int j = 0; j < STAGES; j++) begin
            jp = (j == 0) ? 0 : j - 1;
            if (j == 0) begin
                src_v  = in_valid;
                src_k  = k_in;
                src_a  = a;
                src_b  = b;
                sum_ap = '0;
                sum_ex = '0;
                c_ap   = cin;
                c_ex   = cin;
            end else begin
                src_v  = v_q[jp];
                src_k  = k_q[jp];
                src_a  = a_q[jp];
                src_b  = b_q[jp];
                sum_ap = sap_q[jp];
                sum_ex = sex_q[jp];
                c_ap   = cap_q[jp];
                c_ex   = cex_q[jp];
            end
            for (int i = 0; i < SW; i++) begin
                idx = j * SW + i;
                ai  = src_a[idx];
                bi  = src_b[idx];
                sum_ex[idx] = ai ^ bi ^ c_ex;
                c_ex        = (ai & bi) | (c_ex & (ai ^ bi));
                if (idx < int'(src_k)) begin
                    sum_ap[idx] = (~ai & (bi | c_ap)) | (ai & bi & c_ap);
                    c_ap        = ai;
                end else begin
                    sum_ap[idx] = ai ^ bi ^ c_ap;
                    c_ap        = (ai & bi) | (c_ap & (ai ^ bi));
                end
            end
            v_d[j]   = src_v;
            k_d[j]   = src_k;
            a_d[j]   = src_a;
            b_d[j]   = src_b;
            sap_d[j] = sum_ap;
            sex_d[j] = sum_ex;
            cap_d[j] = c_ap;
            cex_d[j] = c_ex;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < STAGES; j++) begin
                v_q[j]   <= 1'b0;
                k_q[j]   <= '0;
                a_q[j]   <= '0;
                b_q[j]   <= '0;
                sap_q[j] <= '0;
                sex_q[j] <= '0;
                cap_q[j] <= 1'b0;
                cex_q[j] <= 1'b0;
            end
        end else if (en) begin
            for (int j = 0; j < STAGES; j++) begin
                v_q[j]   <= v_d[j];
                k_q[j]   <= k_d[j];
                a_q[j]   <= a_d[j];
                b_q[j]   <= b_d[j];
                sap_q[j] <= sap_d[j];
                sex_q[j] <= sex_d[j];
                cap_q[j] <= cap_d[j];
                cex_q[j] <= cex_d[j];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = sap_q[LAST];
    assign cout      = cap_q[LAST];
    assign err       = {cap_q[LAST], sap_q[LAST]} != {cex_q[LAST], sex_q[LAST]};

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (out_valid && out_ready && err && (err_cnt_q != {CNTW{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_adder_pipe
//
// Self-checking bench for approx_adder_pipe (default parameters). A reference
// function derives {err, cout, s} for each beat from the cell rules and plain
// integer addition; accepted beats queue their expectations and one compare
// process checks the outputs, in_ready, stall stability and err_cnt every
// cycle.
// -----------------------------------------------------------------------------
module tb_approx_adder_pipe;

    localparam int W  = 24;
    localparam int ST = 3;
    localparam int AM = 8;
    localparam int KW = 4;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic [KW-1:0] appr_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  s;
    logic          cout;
    logic          err;
    logic [CW-1:0] err_cnt;
    logic          cnt_clr = 1'b0;

    approx_adder_pipe #(
        .WIDTH(W), .STAGES(ST), .APPR_MAX(AM), .KW(KW), .CNTW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .appr_k(appr_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .err(err),
        .err_cnt(err_cnt), .cnt_clr(cnt_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    // Returns {err, cout, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic [KW-1:0] mk);
        int         kc;
        logic       c;
        logic [1:0] fa;
        logic [W-1:0] sum;
        logic [W:0] exact;
        kc = (int'(mk) > AM) ? AM : int'(mk);
        c = mc;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            if (i < kc) begin
                sum[i] = (~ma[i] & (mb[i] | c)) | (ma[i] & mb[i] & c);
                c = ma[i];
            end else begin
                fa = 2'(ma[i]) + 2'(mb[i]) + 2'(c);
                sum[i] = fa[0];
                c = fa[1];
            end
        end
        exact = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
        return {({c, sum} != exact), c, sum};
    endfunction

    // ---------------- scoreboard / compare ----------------
    logic [W+1:0]  exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic          stall_prev = 1'b0;
    logic [W+2:0]  held = '0;

    always @(negedge clk) begin
        logic [W+1:0] e;
        logic         deliver_err;
        deliver_err = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = '0;
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
            if (stall_prev)
                chk("stall_hold", 64'({out_valid, err, cout, s}), 64'(held));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got s=%0h with no beat outstanding", s);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("result", 64'({err, cout, s}), 64'(e));
                    deliver_err = e[W+1];
                end
            end
            if (cnt_clr)
                exp_cnt = '0;
            else if (deliver_err && exp_cnt != {CW{1'b1}})
                exp_cnt = exp_cnt + CW'(1);
            stall_prev = out_valid && !out_ready;
            held = {out_valid, err, cout, s};
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
    int tog = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (tog == 0);
                    tog = (tog + 1) % 3;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- input driver tasks ----------------
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input logic [KW-1:0] tk);
        logic acc;
        int   n;
        a = ta; b = tbv; cin = tc; appr_k = tk; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) exp_q.push_back(model(ta, tbv, tc, tk));
        else fail_now("send");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    // Called right after a lone beat is accepted into an empty pipe.
    task automatic check_latency(input logic [W+1:0] exp_res);
        int cyc;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        chk("latency", 64'(cyc), 64'(ST));
        chk("directed_result", 64'({err, cout, s}), 64'(exp_res));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_s", 64'(s), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Hand-computed pins of the reference model.
        chk("model_exact", 64'(model(24'hFFFFFF, 24'h000001, 1'b0, 4'd0)), 64'(26'h1000000));
        chk("model_appr_err", 64'(model(24'h00003F, 24'h0, 1'b0, 4'd6)), 64'(26'h2000040));
        chk("model_appr_ok", 64'(model(24'h0, 24'h00003F, 1'b0, 4'd6)), 64'(26'h000003F));
        chk("model_clamp", 64'(model(24'h0, 24'h00003F, 1'b0, 4'd15)), 64'(26'h000003F));

        // Directed cases with fixed literal expectations.
        send(24'hFFFFFF, 24'h000001, 1'b0, 4'd0);
        check_latency(26'h1000000);
        drain();
        chk("cnt_after_exact", 64'(err_cnt), 64'(0));
        send(24'h00003F, 24'h0, 1'b0, 4'd6);
        check_latency(26'h2000040);
        drain();
        chk("cnt_after_err", 64'(err_cnt), 64'(1));
        send(24'h0, 24'h00003F, 1'b0, 4'd6);
        check_latency(26'h000003F);
        drain();
        send(24'h0, 24'h00003F, 1'b0, 4'd15);
        check_latency(26'h000003F);
        drain();
        chk("cnt_after_noerr", 64'(err_cnt), 64'(1));

        // Backpressure: 10 random beats with out_ready following 1,0,0,...
        tog = 0;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++)
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), KW'($urandom_range(0, 15)));
        drain();

        // Random traffic: gaps, random ready, random k, occasional clears.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            cnt_clr = ($urandom_range(0, 19) == 0);
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), KW'($urandom_range(0, 15)));
            cnt_clr = 1'b0;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rdy_mode = 0;
        idle(1);
        drain();

        // cnt_clr coinciding with an erroneous delivery.
        send(24'h00003F, 24'h0, 1'b0, 4'd6);
        drain();
        chk("cnt_nonzero", 64'(err_cnt != 0), 64'(1));
        send(24'h00003F, 24'h0, 1'b0, 4'd6);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_priority", 64'(err_cnt), 64'(0));
        drain();

        // Saturation: 65535 errors reach all-ones, one more must not wrap.
        for (int i = 0; i < 65536; i++)
            send(24'h00003F, 24'h0, 1'b0, 4'd6);
        drain();
        chk("cnt_saturated", 64'(err_cnt), 64'(16'hFFFF));

        // Reset with three beats in flight.
        send(W'($urandom), W'($urandom), 1'b0, 4'd3);
        send(W'($urandom), W'($urandom), 1'b1, 4'd7);
        send(W'($urandom), W'($urandom), 1'b0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_err_cnt", 64'(err_cnt), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(24'h123456, 24'h0F0F0F, 1'b1, 4'd4);
        check_latency(model(24'h123456, 24'h0F0F0F, 1'b1, 4'd4));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_adder_pipe.md
# approx_adder_pipe

Parametrised, pipelined approximate ripple adder, successor to the fixed 24-bit six-approximate-LSB adder. Width and pipeline depth are compile-time parameters. The number of approximate low-order cells is selected per operand at run time (0 = fully exact). The block carries a valid/ready handshake and an on-line error monitor that counts results differing from the exact sum. It sits in the datapath test harness feeding the DFG ILP accuracy/power experiments.

## Interface
- WIDTH, 24, operand/sum width; must be a multiple of STAGES
- STAGES, 3, pipeline register stages; carry chain split into WIDTH/STAGES-bit slices
- APPR_MAX, 8, maximum approximate LSB cells; must satisfy APPR_MAX ≤ WIDTH
- KW, $clog2(APPR_MAX+1), width of appr_k
- CNTW, 16, error counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a, b  in  WIDTH  operands
- cin  in  1  carry in
- appr_k  in  KW  approximate cells for this beat; values > APPR_MAX are clamped to APPR_MAX
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum
- cout  out  1  carry out
- err  out  1  s/cout of current output beat differs from exact a+b+cin
- err_cnt  out  CNTW  saturating count of delivered erroneous beats
- cnt_clr  in  1  synchronous clear of err_cnt

## Operation
- Approximate cell, bit i < k (k = clamped appr_k):
  - cout_i = a_i
  - s_i = (~a_i & (b_i | c_i)) | (a_i & b_i & c_i)
- Bits i ≥ k are exact full adders. Carry ripples from cin through all cells.
- Slice j (bits [j·SW +: SW], SW = WIDTH/STAGES) is computed in stage j.
  - Uses the registered carry from stage j−1 and operand bits delayed by j cycles (skew registers).
  - k travels with the beat.
- An exact reference sum is pipelined alongside the approximate sum. err = ({cout,s} != exact {cout,sum}).
- Advance enable: en = ~out_valid | out_ready. The whole pipe stalls when en = 0. in_ready = en.
- A beat is accepted when in_valid & in_ready. A bubble (valid = 0) enters when in_valid = 0 and en = 1.
- err_cnt increments by 1 on each out_valid & out_ready & err.
  - It saturates at 2^CNTW−1.
  - cnt_clr has priority: when it coincides with an increment, err_cnt becomes 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid = 0, s = 0, cout = 0, err = 0, err_cnt = 0.
  - All stage valid bits = 0, data and skew registers = 0.
  - in_ready = 1 after reset.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. STAGES cycles of registering including the output register.
- Throughput: one beat per cycle while out_ready = 1.
- Stall:
  - s, cout, err and out_valid stay stable while out_valid & ~out_ready.
  - No beat is dropped or duplicated.
- Reset asserted mid-stream discards all in-flight beats immediately. err_cnt returns to 0.
- appr_k changing between consecutive beats takes effect per beat. There is no pipeline flush.
- cnt_clr acts at the clock edge where it is sampled high, regardless of handshake state.

## Test plan
- Exact mode (WIDTH=24, STAGES=3): appr_k=0, a=0xFFFFFF, b=0x000001, cin=0 -> s=0x000000, cout=1, err=0 after 3 cycles; err_cnt stays 0.
- Approximate error: appr_k=6, a=0x00003F, b=0, cin=0 -> s=0x000040, cout=0, err=1; err_cnt=1 after delivery.
- Approximate, no error: appr_k=6, a=0, b=0x00003F, cin=0 -> s=0x00003F, err=0. appr_k=15 is clamped to 8 and yields the same result.
- Backpressure: stream 10 random beats with out_ready toggling 1,0,0,1,… -> results emerge in order, match the model, outputs hold during stalls, and in_ready=0 exactly when out_valid & ~out_ready.
- Counter edges: force err_cnt to 0xFFFF (CNTW=16) via erroneous beats, then deliver one more erroneous beat -> stays 0xFFFF. cnt_clr coinciding with an erroneous delivery -> err_cnt=0.
- Reset mid-operation: pull rst_n low with 3 beats in flight -> out_valid=0 and err_cnt=0 immediately. After release, a new beat produces a correct result with latency 3.
